// File: rtl/seg7_display_reader.sv
// Reader for the six-digit seven-segment display bus. It waits until a frame is stable,
// decodes one digit per cycle and presents the decoded frame through a valid/ready handshake.
module seg7_display_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter bit          ACTIVE_LOW    = 1'b1
) (
    input  logic        CLK_50,
    input  logic        rst_n,
    input  logic [7:0]  disp0,
    input  logic [7:0]  disp1,
    input  logic [7:0]  disp2,
    input  logic [7:0]  disp3,
    input  logic [7:0]  disp4,
    input  logic [7:0]  disp5,
    input  logic        out_ready,
    output logic        out_valid,
    output logic [23:0] digits,
    output logic [5:0]  blank_mask,
    output logic [5:0]  minus_mask,
    output logic [5:0]  dp_mask,
    output logic [5:0]  err_mask,
    output logic        err
);

    typedef enum logic [1:0] {IDLE, SCAN, LOAD, PRESENT} state_e;

    typedef struct packed {
        logic [3:0] nib;
        logic       blank;
        logic       minus;
        logic       dp;
        logic       bad;
    } dec_t;

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    // Bytes are normalised to active-low form; the dp bit is split off before the lookup.
    function automatic dec_t decode(input logic [7:0] raw);
        logic [7:0] c;
        dec_t       r;
        c    = ACTIVE_LOW ? raw : ~raw;
        r    = '0;
        r.dp = ~c[7];
        case (c[6:0])
            7'h40: r.nib = 4'h0;
            7'h79: r.nib = 4'h1;
            7'h24: r.nib = 4'h2;
            7'h30: r.nib = 4'h3;
            7'h19: r.nib = 4'h4;
            7'h12: r.nib = 4'h5;
            7'h02: r.nib = 4'h6;
            7'h78: r.nib = 4'h7;
            7'h00: r.nib = 4'h8;
            7'h10: r.nib = 4'h9;
            7'h08: r.nib = 4'hA;
            7'h03: r.nib = 4'hB;
            7'h46: r.nib = 4'hC;
            7'h21: r.nib = 4'hD;
            7'h06: r.nib = 4'hE;
            7'h0E: r.nib = 4'hF;
            7'h7F: r.blank = 1'b1;
            7'h3F: r.minus = 1'b1;
            default: r.bad = 1'b1;
        endcase
        return r;
    endfunction

    logic [47:0] frame_in;
    assign frame_in = {disp5, disp4, disp3, disp2, disp1, disp0};

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [47:0] sample_q;
    logic [47:0] snap_q, snap_d;
    logic [47:0] last_q, last_d;
    logic        last_vld_q, last_vld_d;
    logic [2:0]  idx_q, idx_d;
    logic [23:0] acc_dig_q, acc_dig_d;
    logic [5:0]  acc_blank_q, acc_blank_d;
    logic [5:0]  acc_minus_q, acc_minus_d;
    logic [5:0]  acc_dp_q, acc_dp_d;
    logic [5:0]  acc_err_q, acc_err_d;
    logic        valid_q, valid_d;
    logic [23:0] dig_q, dig_d;
    logic [5:0]  blank_q, blank_d;
    logic [5:0]  minus_q, minus_d;
    logic [5:0]  dp_q, dp_d;
    logic [5:0]  errm_q, errm_d;
    logic        err_q, err_d;

    logic        stable;
    logic        fresh;
    logic [7:0]  snap_byte;
    dec_t        dec;

    always_comb begin
        cnt_d = '0;
        if (frame_in == sample_q) begin
            cnt_d = (cnt_q == STABLE_MAX) ? cnt_q : cnt_q + 8'd1;
        end
    end

    // Stability is judged on the count including this edge's sample.
    assign stable = (cnt_d == STABLE_MAX);
    assign fresh  = !last_vld_q || (frame_in != last_q);

    always_comb begin
        snap_byte = '0;
        for (int unsigned i = 0; i < 6; i++) begin
            if (idx_q == 3'(i)) snap_byte = snap_q[8*i +: 8];
        end
    end

    assign dec = decode(snap_byte);

    always_comb begin
        state_d     = state_q;
        snap_d      = snap_q;
        last_d      = last_q;
        last_vld_d  = last_vld_q;
        idx_d       = idx_q;
        acc_dig_d   = acc_dig_q;
        acc_blank_d = acc_blank_q;
        acc_minus_d = acc_minus_q;
        acc_dp_d    = acc_dp_q;
        acc_err_d   = acc_err_q;
        valid_d     = valid_q;
        dig_d       = dig_q;
        blank_d     = blank_q;
        minus_d     = minus_q;
        dp_d        = dp_q;
        errm_d      = errm_q;
        err_d       = err_q;
        case (state_q)
            IDLE: begin
                if (stable && fresh) begin
                    snap_d  = frame_in;
                    idx_d   = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                for (int unsigned i = 0; i < 6; i++) begin
                    if (idx_q == 3'(i)) begin
                        acc_dig_d[4*i +: 4] = dec.nib;
                        acc_blank_d[i]      = dec.blank;
                        acc_minus_d[i]      = dec.minus;
                        acc_dp_d[i]         = dec.dp;
                        acc_err_d[i]        = dec.bad;
                    end
                end
                if (idx_q == 3'd5) state_d = LOAD;
                else               idx_d   = idx_q + 3'd1;
            end
            LOAD: begin
                dig_d   = acc_dig_q;
                blank_d = acc_blank_q;
                minus_d = acc_minus_q;
                dp_d    = acc_dp_q;
                errm_d  = acc_err_q;
                err_d   = |acc_err_q;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (valid_q && out_ready) begin
                    last_d     = snap_q;
                    last_vld_d = 1'b1;
                    valid_d    = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sample_q    <= '0;
            snap_q      <= '0;
            last_q      <= '0;
            last_vld_q  <= 1'b0;
            idx_q       <= '0;
            acc_dig_q   <= '0;
            acc_blank_q <= '0;
            acc_minus_q <= '0;
            acc_dp_q    <= '0;
            acc_err_q   <= '0;
            valid_q     <= 1'b0;
            dig_q       <= '0;
            blank_q     <= '0;
            minus_q     <= '0;
            dp_q        <= '0;
            errm_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sample_q    <= frame_in;
            snap_q      <= snap_d;
            last_q      <= last_d;
            last_vld_q  <= last_vld_d;
            idx_q       <= idx_d;
            acc_dig_q   <= acc_dig_d;
            acc_blank_q <= acc_blank_d;
            acc_minus_q <= acc_minus_d;
            acc_dp_q    <= acc_dp_d;
            acc_err_q   <= acc_err_d;
            valid_q     <= valid_d;
            dig_q       <= dig_d;
            blank_q     <= blank_d;
            minus_q     <= minus_d;
            dp_q        <= dp_d;
            errm_q      <= errm_d;
            err_q       <= err_d;
        end
    end

    assign out_valid  = valid_q;
    assign digits     = dig_q;
    assign blank_mask = blank_q;
    assign minus_mask = minus_q;
    assign dp_mask    = dp_q;
    assign err_mask   = errm_q;
    assign err        = err_q;

endmodule

// File: tb/tb_seg7_display_reader.sv
// Directed-vector bench for seg7_display_reader with hand-decoded expected frames.
// Latencies are counted with edge 0 = first clock edge that samples the new frame.
module tb_seg7_display_reader;

    logic        CLK_50;
    logic        rst_n;
    logic [7:0]  disp0, disp1, disp2, disp3, disp4, disp5;
    logic        out_ready;
    logic        out_valid;
    logic [23:0] digits;
    logic [5:0]  blank_mask, minus_mask, dp_mask, err_mask;
    logic        err;

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    seg7_display_reader #(.STABLE_CYCLES(4), .ACTIVE_LOW(1'b1)) dut (
        .CLK_50     (CLK_50),
        .rst_n      (rst_n),
        .disp0      (disp0),
        .disp1      (disp1),
        .disp2      (disp2),
        .disp3      (disp3),
        .disp4      (disp4),
        .disp5      (disp5),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .digits     (digits),
        .blank_mask (blank_mask),
        .minus_mask (minus_mask),
        .dp_mask    (dp_mask),
        .err_mask   (err_mask),
        .err        (err)
    );

    initial begin
        CLK_50 = 1'b0;
        forever #5 CLK_50 = ~CLK_50;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [47:0] got, input logic [47:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_frame(input logic [47:0] f);
        {disp5, disp4, disp3, disp2, disp1, disp0} = f;
    endtask

    task automatic check_out(input string tag, input logic v, input logic [23:0] dig,
                             input logic [5:0] bl, input logic [5:0] mi, input logic [5:0] dp,
                             input logic [5:0] em, input logic e);
        chk({tag, ".valid"}, out_valid, v);
        chk({tag, ".digits"}, digits, dig);
        chk({tag, ".blank"}, blank_mask, bl);
        chk({tag, ".minus"}, minus_mask, mi);
        chk({tag, ".dp"}, dp_mask, dp);
        chk({tag, ".errmask"}, err_mask, em);
        chk({tag, ".err"}, err, e);
    endtask

    // Returns the edge index at which out_valid is first seen high, or -1 on timeout.
    task automatic wait_valid(input int max_edges, output int edges);
        edges = -1;
        for (int k = 0; k < max_edges; k++) begin
            @(posedge CLK_50);
            #1;
            if (out_valid) begin
                edges = k;
                break;
            end
        end
    endtask

    task automatic handshake(input string tag, input logic [23:0] dig);
        out_ready = 1'b1;
        @(posedge CLK_50);
        #1;
        out_ready = 1'b0;
        chk({tag, ".hs_valid"}, out_valid, 1'b0);
        chk({tag, ".hs_hold"}, digits, dig);
    endtask

    task automatic count_valid(input int cycles, output int highs);
        highs = 0;
        for (int k = 0; k < cycles; k++) begin
            @(posedge CLK_50);
            #1;
            if (out_valid) highs++;
        end
    endtask

    localparam logic [47:0] F_T2  = 48'hFF_FF_FF_FF_F9_C0;
    localparam logic [47:0] F_G   = 48'hFF_FF_FF_FF_A4_C0;
    localparam logic [47:0] F_T4A = 48'h3F_C0_C0_F5_C0_C0;
    localparam logic [47:0] F_T4B = 48'h8E_A1_83_88_90_12;
    localparam logic [47:0] F_P   = 48'hFF_FF_FF_B0_99_92;
    localparam logic [47:0] F_Q   = 48'hFF_FF_FF_B0_99_A4;
    localparam logic [47:0] F_R   = 48'hC6_A1_86_8E_88_83;

    initial begin
        int lat;
        int highs;
        int bad;

        rst_n     = 1'b0;
        out_ready = 1'b0;
        set_frame(F_T2);
        repeat (3) @(posedge CLK_50);
        #1;
        check_out("reset", 1'b0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0, 1'b0);

        // Basic frame straight out of reset.
        rst_n = 1'b1;
        wait_valid(40, lat);
        chk("t2.latency", 48'(lat), 48'd11);
        check_out("t2", 1'b1, 24'h000010, 6'b111100, 6'h0, 6'h0, 6'h0, 1'b0);
        handshake("t2", 24'h000010);

        count_valid(30, highs);
        chk("t2.no_rereport", 48'(highs), 48'd0);

        // disp0 glitches every third cycle: never stable long enough.
        highs = 0;
        for (int i = 0; i < 42; i++) begin
            set_frame(F_G);
            if (i % 3 == 2) disp0 = 8'hF9;
            @(posedge CLK_50);
            #1;
            if (out_valid) highs++;
        end
        chk("t3.glitch_quiet", 48'(highs), 48'd0);
        set_frame(F_G);
        wait_valid(40, lat);
        chk("t3.latency", 48'(lat), 48'd11);
        check_out("t3", 1'b1, 24'h000020, 6'b111100, 6'h0, 6'h0, 6'h0, 1'b0);
        handshake("t3", 24'h000020);

        // Illegal code in digit 2, minus with dp lit in digit 5.
        set_frame(F_T4A);
        wait_valid(40, lat);
        chk("t4a.latency", 48'(lat), 48'd11);
        check_out("t4a", 1'b1, 24'h000000, 6'h0, 6'b100000, 6'b100000, 6'b000100, 1'b1);
        handshake("t4a", 24'h000000);

        // Hex letters and a dp on a legal digit.
        set_frame(F_T4B);
        wait_valid(40, lat);
        chk("t4b.latency", 48'(lat), 48'd11);
        check_out("t4b", 1'b1, 24'hFDBA95, 6'h0, 6'h0, 6'b000001, 6'h0, 1'b0);
        handshake("t4b", 24'hFDBA95);

        // Backpressure: outputs frozen while input moves on to a new frame.
        set_frame(F_P);
        wait_valid(40, lat);
        chk("t5.latency", 48'(lat), 48'd11);
        check_out("t5p", 1'b1, 24'h000345, 6'b111000, 6'h0, 6'h0, 6'h0, 1'b0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 2) set_frame(F_Q);
            @(posedge CLK_50);
            #1;
            if (!(out_valid && digits == 24'h000345)) bad++;
        end
        chk("t5.frozen", 48'(bad), 48'd0);
        handshake("t5p", 24'h000345);
        // Counter already saturated: snapshot on the first IDLE edge, valid 7 edges later.
        wait_valid(40, lat);
        chk("t5.q_latency", 48'(lat), 48'd7);
        check_out("t5q", 1'b1, 24'h000342, 6'b111000, 6'h0, 6'h0, 6'h0, 1'b0);
        handshake("t5q", 24'h000342);
        count_valid(30, highs);
        chk("t5.no_rereport", 48'(highs), 48'd0);

        // Reset on the third SCAN edge: that frame is dropped, then reported afresh.
        set_frame(F_R);
        highs = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge CLK_50);
            #1;
            if (out_valid) highs++;
        end
        rst_n = 1'b0;
        #1;
        check_out("t6.async_clr", 1'b0, 24'h0, 6'h0, 6'h0, 6'h0, 6'h0, 1'b0);
        chk("t6.no_early_valid", 48'(highs), 48'd0);
        repeat (2) @(posedge CLK_50);
        #1;
        chk("t6.held_in_reset", out_valid, 1'b0);
        rst_n = 1'b1;
        wait_valid(40, lat);
        chk("t6.latency", 48'(lat), 48'd11);
        check_out("t6", 1'b1, 24'hCDEFAB, 6'h0, 6'h0, 6'h0, 6'h0, 1'b0);
        handshake("t6", 24'hCDEFAB);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
